// File: rtl/lcd_pkg.sv
// lcd_pkg
// Shared definitions for the RGB-LCD timing generator.
//   - COORD_W / COORD_MAX : width and largest value of the h/v counters and
//                           of the REQ_X/REQ_Y coordinates.
//   - lcd_state_t         : run/stop state encoding (IDLE, RUN, DRAIN).
//   - region_* functions  : region decode for one axis laid out as
//                           sync | back porch | active | front porch.
//                           The top evaluates them into localparams (TH, TV,
//                           active start/end) for its own geometry.
package lcd_pkg;

  localparam int COORD_W   = 11;
  localparam int COORD_MAX = (1 << COORD_W) - 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } lcd_state_t;

  // Full period of one axis (clocks per line or lines per frame).
  function automatic int region_total(input int sync, input int back,
                                      input int active, input int front);
    return sync + back + active + front;
  endfunction

  // First counter value of the active window.
  function automatic int region_act_start(input int sync, input int back);
    return sync + back;
  endfunction

  // First counter value after the active window (exclusive end).
  function automatic int region_act_end(input int sync, input int back,
                                        input int active);
    return sync + back + active;
  endfunction

endpackage

// File: rtl/lcd_delay_line.sv
// lcd_delay_line
// Parametrised shift register used to delay the panel timing bits so they
// line up with a pipelined pixel source. DEPTH=0 degenerates to a wire.
// Ports:
//   clk       in  1      : clock
//   rst       in  1      : synchronous active-high reset, loads RESET_VAL
//   din       in  WIDTH  : value entering the line
//   dout      out WIDTH  : value DEPTH clocks later
module lcd_delay_line #(
  parameter int               DEPTH     = 2,
  parameter int               WIDTH     = 3,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  if (DEPTH == 0) begin : g_wire
    // Clock and reset have no job here; fold them into a named sink.
    logic unused_ctrl;
    assign unused_ctrl = clk | rst;
    assign dout        = din;
  end else begin : g_shift
    logic [WIDTH-1:0] stages [DEPTH];

    always_ff @(posedge clk) begin
      if (rst) begin
        for (int i = 0; i < DEPTH; i++) stages[i] <= RESET_VAL;
      end else begin
        stages[0] <= din;
        for (int i = 1; i < DEPTH; i++) stages[i] <= stages[i-1];
      end
    end

    assign dout = stages[DEPTH-1];
  end

endmodule

// File: rtl/lcd_timing_gen.sv
// lcd_timing_gen
// RGB-LCD timing generator: HSYNC/VSYNC/DEN for an arbitrary panel geometry,
// a pixel-request port running LEAD clocks ahead of DEN, a backlight PWM and
// a run/stop control that only ever stops on a frame boundary.
// Ports:
//   clk          in  1         : pixel clock
//   rst          in  1         : synchronous active-high reset
//   en           in  1         : run request
//   brightness   in  PWM_BITS  : backlight duty, sampled at PWM period start
//   lcd_hsync    out 1         : horizontal sync, polarity HS_POL, registered
//   lcd_vsync    out 1         : vertical sync, polarity VS_POL, registered
//   lcd_den      out 1         : data enable, polarity DE_POL, registered
//   lcd_pwm      out 1         : backlight PWM, registered
//   req_valid    out 1         : req_x/req_y address an active pixel
//   req_x/req_y  out 11        : requested pixel coordinate (0 when invalid)
//   frame_start  out 1         : strobe on the first counter cycle of a frame
//   line_start   out 1         : strobe on the first counter cycle of a line
//   busy         out 1         : high while running or draining a frame
module lcd_timing_gen
  import lcd_pkg::*;
#(
  parameter int LCD_WIDTH  = 480,
  parameter int LCD_HEIGHT = 272,
  parameter int HF         = 2,
  parameter int HP         = 40,
  parameter int HB         = 1,
  parameter int VF         = 4,
  parameter int VP         = 9,
  parameter int VB         = 1,
  parameter bit HS_POL     = 1'b0,
  parameter bit VS_POL     = 1'b0,
  parameter bit DE_POL     = 1'b1,
  parameter int LEAD       = 2,
  parameter int PWM_BITS   = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic [PWM_BITS-1:0] brightness,
  output logic                lcd_hsync,
  output logic                lcd_vsync,
  output logic                lcd_den,
  output logic                lcd_pwm,
  output logic                req_valid,
  output logic [COORD_W-1:0]  req_x,
  output logic [COORD_W-1:0]  req_y,
  output logic                frame_start,
  output logic                line_start,
  output logic                busy
);

  localparam int TH = region_total(HP, HB, LCD_WIDTH, HF);
  localparam int TV = region_total(VP, VB, LCD_HEIGHT, VF);

  localparam logic [COORD_W-1:0] H_LAST   = COORD_W'(TH - 1);
  localparam logic [COORD_W-1:0] V_LAST   = COORD_W'(TV - 1);
  localparam logic [COORD_W-1:0] H_SYNC_E = COORD_W'(HP);
  localparam logic [COORD_W-1:0] V_SYNC_E = COORD_W'(VP);
  localparam logic [COORD_W-1:0] H_ACT_S  = COORD_W'(region_act_start(HP, HB));
  localparam logic [COORD_W-1:0] H_ACT_E  = COORD_W'(region_act_end(HP, HB, LCD_WIDTH));
  localparam logic [COORD_W-1:0] V_ACT_S  = COORD_W'(region_act_start(VP, VB));
  localparam logic [COORD_W-1:0] V_ACT_E  = COORD_W'(region_act_end(VP, VB, LCD_HEIGHT));

  localparam logic [PWM_BITS-1:0] P_LAST = PWM_BITS'((1 << PWM_BITS) - 2);

  // Panel bits are carried as {hsync, vsync, den} already at pin level.
  localparam logic [2:0] PANEL_POL  = {HS_POL, VS_POL, DE_POL};
  localparam logic [2:0] PANEL_IDLE = ~PANEL_POL;

  // Geometry that cannot be represented is rejected at elaboration.
  if (TH > COORD_MAX || TV > COORD_MAX) begin : g_err_range
    $error("lcd_timing_gen: TH=%0d / TV=%0d exceed the 11-bit counters", TH, TV);
  end
  if (HF < 1 || HP < 1 || HB < 1 || VF < 1 || VP < 1 || VB < 1) begin : g_err_porch
    $error("lcd_timing_gen: porch and pulse widths must all be at least 1");
  end
  if (LCD_WIDTH < 1 || LCD_HEIGHT < 1 || LEAD < 0 || LEAD > 15) begin : g_err_shape
    $error("lcd_timing_gen: empty active area or LEAD outside 0..15");
  end

  lcd_state_t         state, state_next;
  logic [COORD_W-1:0] h, v, h_next, v_next;
  logic               running, frame_end;
  logic               h_act, v_act, pix_act;
  logic               raw_hs, raw_vs;
  logic [2:0]         panel_now, panel_q, panel_dly;
  logic [PWM_BITS-1:0] pwm_cnt, duty, duty_now;

  assign running   = (state != ST_IDLE);
  assign frame_end = (h == H_LAST) && (v == V_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      h     <= '0;
      v     <= '0;
    end else begin
      state <= state_next;
      h     <= h_next;
      v     <= v_next;
    end
  end

  // Counters only move while a frame is in flight. Leaving RUN/DRAIN is
  // allowed solely on the last counter value, so a frame is never cut short;
  // DRAIN simply remembers that EN went away and can fall back into RUN.
  always_comb begin
    state_next = state;
    h_next     = h;
    v_next     = v;
    case (state)
      ST_IDLE: begin
        h_next = '0;
        v_next = '0;
        if (en) state_next = ST_RUN;
      end
      ST_RUN, ST_DRAIN: begin
        if (h == H_LAST) begin
          h_next = '0;
          v_next = (v == V_LAST) ? '0 : v + COORD_W'(1);
        end else begin
          h_next = h + COORD_W'(1);
        end
        if (frame_end && !en) state_next = ST_IDLE;
        else if (en)          state_next = ST_RUN;
        else                  state_next = ST_DRAIN;
      end
      default: begin
        state_next = ST_IDLE;
        h_next     = '0;
        v_next     = '0;
      end
    endcase
  end

  // Region decode is gated with 'running' because the idle counters sit at
  // h=v=0, which would otherwise look like a sync region and a frame start.
  assign h_act   = (h >= H_ACT_S) && (h < H_ACT_E);
  assign v_act   = (v >= V_ACT_S) && (v < V_ACT_E);
  assign pix_act = running && h_act && v_act;
  assign raw_hs  = running && (h < H_SYNC_E);
  assign raw_vs  = running && (v < V_SYNC_E);

  always_ff @(posedge clk) begin
    if (rst) begin
      req_valid   <= 1'b0;
      req_x       <= '0;
      req_y       <= '0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      req_valid   <= pix_act;
      req_x       <= pix_act ? h - H_ACT_S : '0;
      req_y       <= pix_act ? v - V_ACT_S : '0;
      line_start  <= running && (h == '0);
      frame_start <= running && (h == '0) && (v == '0);
    end
  end

  // Polarity is applied before the first register so every panel pin comes
  // straight from a flop and the delay line shifts pin levels, not raw bits.
  assign panel_now = ~({raw_hs, raw_vs, pix_act} ^ PANEL_POL);

  always_ff @(posedge clk) begin
    if (rst) panel_q <= PANEL_IDLE;
    else     panel_q <= panel_now;
  end

  lcd_delay_line #(
    .DEPTH     (LEAD),
    .WIDTH     (3),
    .RESET_VAL (PANEL_IDLE)
  ) u_delay (
    .clk  (clk),
    .rst  (rst),
    .din  (panel_q),
    .dout (panel_dly)
  );

  assign lcd_hsync = panel_dly[2];
  assign lcd_vsync = panel_dly[1];
  assign lcd_den   = panel_dly[0];
  assign busy      = running;

  // The PWM period is 2^PWM_BITS-1 clocks so the all-ones duty is solidly
  // high. The duty sampled on p==0 is used in that same cycle, which keeps
  // every period's high time equal to the value captured at its start.
  assign duty_now = (pwm_cnt == '0) ? brightness : duty;

  always_ff @(posedge clk) begin
    if (rst) begin
      pwm_cnt <= '0;
      duty    <= '0;
      lcd_pwm <= 1'b0;
    end else begin
      if (pwm_cnt == '0) duty <= brightness;
      lcd_pwm <= (pwm_cnt < duty_now);
      pwm_cnt <= (pwm_cnt == P_LAST) ? '0 : pwm_cnt + PWM_BITS'(1);
    end
  end

endmodule

// File: tb/tb_lcd_timing_gen.sv
// tb_lcd_timing_gen
// Self-checking bench for lcd_timing_gen. Two instances share the stimulus:
//   dut_a : small geometry, LEAD=2, default polarities
//   dut_b : same geometry, LEAD=0, active-high HSYNC, active-low DEN
// A frame-level model (frame cycle index, history of pin levels, PWM period
// arithmetic) predicts every output each cycle; directed scenarios add
// hand-computed literal checks.
module tb_lcd_timing_gen;

  localparam int W = 4, HGT = 3, HF = 1, HP = 2, HB = 1, VF = 1, VP = 1, VB = 1;
  localparam int TH = HP + HB + W + HF;
  localparam int TV = VP + VB + HGT + VF;
  localparam int FRAME = TH * TV;
  localparam int LEAD_A = 2;
  localparam int PWM_PERIOD = 255;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0;
  logic [7:0] brightness = 8'd0;

  logic        a_hsync, a_vsync, a_den, a_pwm, a_req_valid, a_frame_start, a_line_start, a_busy;
  logic [10:0] a_req_x, a_req_y;
  logic        b_hsync, b_vsync, b_den, b_pwm, b_req_valid, b_frame_start, b_line_start, b_busy;
  logic [10:0] b_req_x, b_req_y;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  lcd_timing_gen #(
    .LCD_WIDTH(W), .LCD_HEIGHT(HGT), .HF(HF), .HP(HP), .HB(HB),
    .VF(VF), .VP(VP), .VB(VB), .HS_POL(1'b0), .VS_POL(1'b0), .DE_POL(1'b1),
    .LEAD(LEAD_A), .PWM_BITS(8)
  ) dut_a (
    .clk(clk), .rst(rst), .en(en), .brightness(brightness),
    .lcd_hsync(a_hsync), .lcd_vsync(a_vsync), .lcd_den(a_den), .lcd_pwm(a_pwm),
    .req_valid(a_req_valid), .req_x(a_req_x), .req_y(a_req_y),
    .frame_start(a_frame_start), .line_start(a_line_start), .busy(a_busy)
  );

  lcd_timing_gen #(
    .LCD_WIDTH(W), .LCD_HEIGHT(HGT), .HF(HF), .HP(HP), .HB(HB),
    .VF(VF), .VP(VP), .VB(VB), .HS_POL(1'b1), .VS_POL(1'b0), .DE_POL(1'b0),
    .LEAD(0), .PWM_BITS(8)
  ) dut_b (
    .clk(clk), .rst(rst), .en(en), .brightness(brightness),
    .lcd_hsync(b_hsync), .lcd_vsync(b_vsync), .lcd_den(b_den), .lcd_pwm(b_pwm),
    .req_valid(b_req_valid), .req_x(b_req_x), .req_y(b_req_y),
    .frame_start(b_frame_start), .line_start(b_line_start), .busy(b_busy)
  );

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0d expected=%0d at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input bit r, input bit e, input logic [7:0] b);
    rst        = r;
    en         = e;
    brightness = b;
  endtask

  function automatic bit pinLevel(input bit asserted, input bit pol);
    return asserted ? pol : ~pol;
  endfunction

  // Model state: whether a frame is in flight and which of its FRAME cycles
  // the counters are on; hist[k] holds the raw {hs,vs,den} that the request
  // side produced k+1 edges ago; PWM is tracked as elapsed cycles since reset.
  bit        model_valid = 1'b0;
  bit        m_run;
  int        m_c;
  int        pwm_t;
  int        m_duty;
  bit [2:0]  hist [16];
  bit        exp_valid, exp_fs, exp_ls, exp_busy, exp_pwm;
  int        exp_x, exp_y;
  int        hh, vv, pos;
  bit        act;

  always @(posedge clk) begin
    if (rst) begin
      m_run = 1'b0; m_c = 0; pwm_t = 0; m_duty = 0;
      for (int i = 0; i < 16; i++) hist[i] = 3'b000;
      exp_valid = 0; exp_x = 0; exp_y = 0; exp_fs = 0; exp_ls = 0; exp_pwm = 0;
    end else begin
      hh  = m_c % TH;
      vv  = m_c / TH;
      act = m_run && hh >= HP + HB && hh < HP + HB + W && vv >= VP + VB && vv < VP + VB + HGT;
      exp_valid = act;
      exp_x     = act ? hh - HP - HB : 0;
      exp_y     = act ? vv - VP - VB : 0;
      exp_ls    = m_run && hh == 0;
      exp_fs    = m_run && m_c == 0;
      for (int i = 15; i > 0; i--) hist[i] = hist[i-1];
      hist[0] = {m_run && hh < HP, m_run && vv < VP, act};
      if (!m_run) begin
        if (en) begin m_run = 1'b1; m_c = 0; end
      end else if (m_c == FRAME - 1 && !en) begin
        m_run = 1'b0; m_c = 0;
      end else begin
        m_c = (m_c + 1) % FRAME;
      end
      pos = pwm_t % PWM_PERIOD;
      if (pos == 0) m_duty = brightness;
      exp_pwm = pos < m_duty;
      pwm_t++;
    end
    exp_busy    = m_run;
    model_valid = 1'b1;
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (model_valid) begin
      checkOutput("a_req_valid", a_req_valid, exp_valid);
      checkOutput("a_req_x", a_req_x, exp_x);
      checkOutput("a_req_y", a_req_y, exp_y);
      checkOutput("a_frame_start", a_frame_start, exp_fs);
      checkOutput("a_line_start", a_line_start, exp_ls);
      checkOutput("a_busy", a_busy, exp_busy);
      checkOutput("a_pwm", a_pwm, exp_pwm);
      checkOutput("a_hsync", a_hsync, pinLevel(hist[LEAD_A][2], 1'b0));
      checkOutput("a_vsync", a_vsync, pinLevel(hist[LEAD_A][1], 1'b0));
      checkOutput("a_den", a_den, pinLevel(hist[LEAD_A][0], 1'b1));
      checkOutput("b_req_valid", b_req_valid, exp_valid);
      checkOutput("b_req_x", b_req_x, exp_x);
      checkOutput("b_req_y", b_req_y, exp_y);
      checkOutput("b_frame_start", b_frame_start, exp_fs);
      checkOutput("b_line_start", b_line_start, exp_ls);
      checkOutput("b_busy", b_busy, exp_busy);
      checkOutput("b_pwm", b_pwm, exp_pwm);
      checkOutput("b_hsync", b_hsync, pinLevel(hist[0][2], 1'b1));
      checkOutput("b_vsync", b_vsync, pinLevel(hist[0][1], 1'b0));
      checkOutput("b_den", b_den, pinLevel(hist[0][0], 1'b0));
    end
  end

  // Returns at the negedge where dut_a shows frame_start, bounded in cycles.
  task automatic waitFrameStart();
    bit seen = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge clk);
      if (a_frame_start) seen = 1'b1;
    end
    checkOutput("frame_start_seen", seen, 1);
  endtask

  initial begin : watchdog
    #2000000;
    $display("[TB] FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "[TB] simulation did not finish");
  end

  initial begin : stimulus
    int gap, fs_cnt, val_cnt, hs_low, vs_low, den_hi, xsum, bden_lo, bhs_hi, bden_align, hi_cnt;
    logic [7:0] duties [3];
    duties[0] = 8'd64; duties[1] = 8'd255; duties[2] = 8'd0;

    applyStimulus(1'b1, 1'b0, 8'd0);
    repeat (3) @(negedge clk);

    // Reset state of every pin.
    checkOutput("reset_a_hsync", a_hsync, 1);
    checkOutput("reset_a_den", a_den, 0);
    checkOutput("reset_b_hsync", b_hsync, 0);
    checkOutput("reset_b_den", b_den, 1);
    checkOutput("reset_busy", a_busy, 0);

    // Scenario 1/2/6: continuous run, frame period and per-frame counts.
    applyStimulus(1'b0, 1'b1, 8'd100);
    waitFrameStart();
    gap = 0;
    do begin
      @(negedge clk);
      gap++;
    end while (!a_frame_start && gap < 100);
    checkOutput("frame_period", gap, 48);
    fs_cnt = 0; val_cnt = 0; hs_low = 0; vs_low = 0; den_hi = 0; xsum = 0;
    bden_lo = 0; bhs_hi = 0; bden_align = 0;
    for (int i = 0; i < FRAME; i++) begin
      if (i > 0) @(negedge clk);
      fs_cnt  += int'(a_frame_start);
      val_cnt += int'(a_req_valid);
      if (a_req_valid) xsum += int'(a_req_x);
      hs_low  += int'(!a_hsync);
      vs_low  += int'(!a_vsync);
      den_hi  += int'(a_den);
      bden_lo += int'(!b_den);
      bhs_hi  += int'(b_hsync);
      bden_align += int'(b_den == !b_req_valid);
    end
    checkOutput("frame_starts_per_frame", fs_cnt, 1);
    checkOutput("req_valid_per_frame", val_cnt, 12);
    checkOutput("req_x_sum_per_frame", xsum, 18);
    checkOutput("hsync_low_per_frame", hs_low, 12);
    checkOutput("vsync_low_per_frame", vs_low, 8);
    checkOutput("den_high_per_frame", den_hi, 12);
    checkOutput("b_den_low_per_frame", bden_lo, 12);
    checkOutput("b_hsync_high_per_frame", bhs_hi, 12);
    checkOutput("b_den_aligned_cycles", bden_align, 48);

    // Scenario 3: drop EN at counter cycle 20; frame completes, then idle.
    waitFrameStart();
    repeat (19) @(negedge clk);
    en = 1'b0;
    repeat (27) @(negedge clk);
    checkOutput("busy_at_last_counter", a_busy, 1);
    @(negedge clk);
    checkOutput("busy_after_last_counter", a_busy, 0);
    fs_cnt = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      fs_cnt += int'(a_frame_start);
    end
    checkOutput("frame_starts_while_stopped", fs_cnt, 0);

    // Scenario 4: reset at counter cycle 30 aborts the frame immediately.
    en = 1'b1;
    waitFrameStart();
    repeat (29) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("abort_a_hsync", a_hsync, 1);
    checkOutput("abort_a_vsync", a_vsync, 1);
    checkOutput("abort_a_den", a_den, 0);
    checkOutput("abort_pwm", a_pwm, 0);
    checkOutput("abort_req_valid", a_req_valid, 0);
    checkOutput("abort_busy", a_busy, 0);
    checkOutput("abort_b_hsync", b_hsync, 0);
    checkOutput("abort_b_den", b_den, 1);
    applyStimulus(1'b0, 1'b0, 8'd0);

    // Scenario 5: PWM high time per period for typical and extreme duties.
    for (int d = 0; d < 3; d++) begin
      brightness = duties[d];
      repeat (2 * PWM_PERIOD + 10) @(negedge clk);
      hi_cnt = 0;
      for (int i = 0; i < PWM_PERIOD; i++) begin
        @(negedge clk);
        hi_cnt += int'(a_pwm);
      end
      checkOutput($sformatf("pwm_high_duty_%0d", duties[d]), hi_cnt, int'(duties[d]));
    end

    // Randomized run/stop, brightness changes and occasional resets.
    for (int i = 0; i < 1500; i++) begin
      @(negedge clk);
      if ($urandom_range(15) == 0) en = ~en;
      rst = ($urandom_range(399) == 0);
      if ($urandom_range(49) == 0) begin
        case ($urandom_range(3))
          0: brightness = 8'd0;
          1: brightness = 8'd255;
          default: brightness = 8'($urandom_range(255));
        endcase
      end
    end
    rst = 1'b0;
    repeat (5) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
